// File: rtl/counter_ud_cmd_seq.sv
// rtl/counter_ud_cmd_seq.sv - command FIFO and sequencer driving an up/down counter's load/direction inputs
module counter_ud_cmd_seq #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_data,
  input  logic [LEN_W-1:0]         cmd_len,
  output logic [WIDTH-1:0]         load,
  output logic                     load_en,
  output logic                     down,
  output logic                     busy,
  output logic                     cmd_done,
  output logic                     cmd_err,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 2 + WIDTH + LEN_W;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state;
  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LEN_W-1:0]  remaining;
  logic              full;
  logic              empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic              exec_nxt;
  logic [LW-1:0]     level_nxt;
  logic [1:0]        head_op;
  logic [WIDTH-1:0]  head_data;
  logic [LEN_W-1:0]  head_len;

  assign full      = (fifo_level == LW'(DEPTH));
  assign empty     = (fifo_level == '0);
  assign cmd_ready = !full;
  assign accept    = cmd_valid && !full;
  // Reserved ops complete the handshake but never occupy a FIFO slot.
  assign push      = accept && (cmd_op != OP_RSVD);
  assign pop       = (state == IDLE) && !empty;

  assign {head_op, head_data, head_len} = mem[rd_ptr];

  always_comb begin
    level_nxt = fifo_level;
    if (push && !pop)
      level_nxt = fifo_level + 1'b1;
    else if (pop && !push)
      level_nxt = fifo_level - 1'b1;
  end

  assign exec_nxt = (state == IDLE) ? pop : (remaining != '0);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {cmd_op, cmd_data, cmd_len};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      remaining  <= '0;
      load       <= '0;
      load_en    <= 1'b0;
      down       <= 1'b0;
      busy       <= 1'b0;
      cmd_done   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(push);
      rd_ptr     <= rd_ptr + PW'(pop);
      fifo_level <= level_nxt;
      cmd_err    <= accept && (cmd_op == OP_RSVD);
      busy       <= exec_nxt || (level_nxt != '0);
      case (state)
        IDLE: begin
          load_en  <= 1'b0;
          cmd_done <= 1'b0;
          if (pop) begin
            state <= EXEC;
            if (head_op == OP_LOAD) begin
              load      <= head_data;
              load_en   <= 1'b1;
              cmd_done  <= 1'b1;
              remaining <= '0;
            end else if (head_len == '0) begin
              cmd_done  <= 1'b1;
              remaining <= '0;
            end else begin
              // remaining holds the active cycles still to come after this one.
              down      <= (head_op == OP_DOWN);
              remaining <= head_len - 1'b1;
              cmd_done  <= (head_len == LEN_W'(1));
            end
          end
        end
        EXEC: begin
          if (remaining == '0) begin
            state    <= IDLE;
            load_en  <= 1'b0;
            cmd_done <= 1'b0;
          end else begin
            remaining <= remaining - 1'b1;
            cmd_done  <= (remaining == LEN_W'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
